mem_stage_lsu: RTL and testbench

//  Next-gen MEM pipeline stage between EX and WB: registered EX->WB forwarding plus a real load/store unit.

---
 rtl/mem_stage_lsu.sv | 190 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: registered EX->WB forwarding plus a single-outstanding load/store unit
// on a req/gnt/rvalid data-memory port, with byte masks, store-lane replication and load extension.
module mem_stage_lsu #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_wd,
    input  logic                  in_wreg,
    input  logic [XLEN-1:0]       in_wdata,
    input  logic                  in_mem_en,
    input  logic                  in_mem_we,
    input  logic [2:0]            in_funct3,
    input  logic [XLEN-1:0]       in_sdata,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    output logic [XLEN/8-1:0]     dmem_wmask,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_wd,
    output logic                  out_wreg,
    output logic [XLEN-1:0]       out_wdata,
    output logic                  out_exc
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                  state_q;
    logic                    dmem_req_q, dmem_we_q;
    logic [ADDR_W-1:0]       dmem_addr_q;
    logic [XLEN-1:0]         dmem_wdata_q;
    logic [NB-1:0]           dmem_wmask_q;
    logic                    out_valid_q, out_wreg_q, out_exc_q;
    logic [REG_ADDR_W-1:0]   out_wd_q, wd_q;
    logic [XLEN-1:0]         out_wdata_q, wdata_q;
    logic                    wreg_q;
    logic [2:0]              f3_q;
    logic [OFF_W-1:0]        off_q;
    logic [OFF_W-1:0]        in_off;
    logic                    acc, exc_d;

    function automatic logic [NB-1:0] byte_mask(input logic [1:0] sz, input logic [OFF_W-1:0] off);
        logic [NB-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++)
            if (i < (1 << sz)) m[i] = 1'b1;
        return m << off;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [OFF_W-1:0] off);
        logic [OFF_W-1:0] m;
        m = '0;
        for (int i = 0; i < OFF_W; i++)
            if (i < int'(sz)) m[i] = 1'b1;
        return (off & m) != '0;
    endfunction

    function automatic int size_bits(input logic [1:0] sz);
        int nb;
        nb = 8 << sz;
        if (nb > XLEN) nb = XLEN;
        return nb;
    endfunction

    function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] d, input logic [1:0] sz);
        logic [XLEN-1:0] r;
        int              nb;
        nb = size_bits(sz);
        for (int i = 0; i < XLEN; i++) r[i] = d[i % nb];
        return r;
    endfunction

    // Shift the addressed lane down, then sign- or zero-fill above the access size.
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rdata, input logic [2:0] f3,
                                                 input logic [OFF_W-1:0] off);
        logic [XLEN-1:0] sh;
        int              nb;
        sh = rdata >> {off, 3'b000};
        nb = size_bits(f3[1:0]);
        for (int i = 0; i < XLEN; i++)
            if (i >= nb) sh[i] = !f3[2] && sh[nb-1];
        return sh;
    endfunction

    assign in_off   = in_wdata[OFF_W-1:0];
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign acc      = in_valid && in_ready;

    always_comb begin
        exc_d = 1'b0;
        if (in_mem_en) begin
            exc_d = is_misaligned(in_funct3[1:0], in_off)
                 || (XLEN == 32 && in_funct3[1:0] == 2'd3)
                 || (!in_mem_we && in_funct3 == 3'b111)
                 || (!in_mem_we && XLEN == 32 && in_funct3 == 3'b110)
                 || (in_mem_we && in_funct3[2]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_wmask_q <= '0;
            out_valid_q  <= 1'b0;
            out_wreg_q   <= 1'b0;
            out_exc_q    <= 1'b0;
            out_wd_q     <= '0;
            out_wdata_q  <= '0;
            wd_q         <= '0;
            wreg_q       <= 1'b0;
            wdata_q      <= '0;
            f3_q         <= '0;
            off_q        <= '0;
        end else begin
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (acc) begin
                    wd_q    <= in_wd;
                    wreg_q  <= in_wreg;
                    wdata_q <= in_wdata;
                    f3_q    <= in_funct3;
                    off_q   <= in_off;
                    if (in_mem_en && !exc_d) begin
                        state_q      <= REQ;
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= in_mem_we;
                        dmem_addr_q  <= {in_wdata[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        dmem_wdata_q <= replicate(in_sdata, in_funct3[1:0]);
                        dmem_wmask_q <= byte_mask(in_funct3[1:0], in_off);
                    end else begin
                        out_valid_q <= 1'b1;
                        out_wd_q    <= in_wd;
                        out_wreg_q  <= in_wreg && !exc_d;
                        out_wdata_q <= in_wdata;
                        out_exc_q   <= exc_d;
                    end
                end
                REQ: if (dmem_gnt) begin
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                    if (dmem_we_q) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b1;
                        out_wd_q    <= wd_q;
                        out_wreg_q  <= wreg_q;
                        out_wdata_q <= wdata_q;
                        out_exc_q   <= 1'b0;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: if (dmem_rvalid) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b1;
                    out_wd_q    <= wd_q;
                    out_wreg_q  <= wreg_q;
                    out_wdata_q <= load_ext(dmem_rdata, f3_q, off_q);
                    out_exc_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_wmask = dmem_wmask_q;
    assign out_valid  = out_valid_q;
    assign out_wd     = out_wd_q;
    assign out_wreg   = out_wreg_q;
    assign out_wdata  = out_wdata_q;
    assign out_exc    = out_exc_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (XLEN=64): expected WB entries go into a scoreboard queue
// and a negedge monitor pops and compares them on every out_valid&&out_ready transfer.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_wd = '0;
    logic        in_wreg = 1'b0;
    logic [63:0] in_wdata = '0;
    logic        in_mem_en = 1'b0;
    logic        in_mem_we = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [63:0] in_sdata = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wmask;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [63:0] dmem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_wd;
    logic        out_wreg;
    logic [63:0] out_wdata;
    logic        out_exc;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [63:0] wdata;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mem_stage_lsu #(.XLEN(64), .REG_ADDR_W(5), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_wd(in_wd), .in_wreg(in_wreg),
        .in_wdata(in_wdata), .in_mem_en(in_mem_en), .in_mem_we(in_mem_we),
        .in_funct3(in_funct3), .in_sdata(in_sdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_wd(out_wd), .out_wreg(out_wreg),
        .out_wdata(out_wdata), .out_exc(out_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: transfers happen at the posedge following this negedge sample.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual wd=%0d wdata=%h required none", out_wd, out_wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_wdata", out_wdata, e.wdata);
                chk("out_ctl{wd,wreg,exc}", 64'({out_wd, out_wreg, out_exc}), 64'({e.wd, e.wreg, e.exc}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [4:0] wd, input logic wreg, input logic [63:0] wdata,
                        input logic mem_en, input logic we, input logic [2:0] f3, input logic [63:0] sdata);
        bit ok;
        in_valid = 1'b1; in_wd = wd; in_wreg = wreg; in_wdata = wdata;
        in_mem_en = mem_en; in_mem_we = we; in_funct3 = f3; in_sdata = sdata;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready0 required=in_ready1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_mem_en = 1'b0;
    endtask

    task automatic grant_and_respond(input bit is_load, input logic [63:0] rdata);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        if (is_load) begin
            dmem_rvalid = 1'b1; dmem_rdata = rdata;
            @(posedge clk); #1;
            dmem_rvalid = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_dmem_req", 64'(dmem_req), 64'd0);
        chk("reset_out_wdata", out_wdata, 64'd0);
        chk("reset_wmask", 64'(dmem_wmask), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: ALU op, latency 1, no memory request
        sb.push_back('{wd: 5'd5, wreg: 1'b1, wdata: 64'h1234, exc: 1'b0});
        send(5'd5, 1'b1, 64'h1234, 1'b0, 1'b0, 3'b000, 64'd0);
        @(negedge clk);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_no_req", 64'(dmem_req), 64'd0);
        @(posedge clk); #1;

        // 2: SB with three cycles of withheld grant
        sb.push_back('{wd: 5'd0, wreg: 1'b0, wdata: 64'h1003, exc: 1'b0});
        send(5'd0, 1'b0, 64'h1003, 1'b1, 1'b1, 3'b000, 64'hAB);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t2_req_held", 64'(dmem_req), 64'd1);
            chk("t2_in_ready", 64'(in_ready), 64'd0);
            chk("t2_addr", 64'(dmem_addr), 64'h1000);
            chk("t2_wmask", 64'(dmem_wmask), 64'h08);
            chk("t2_wdata", dmem_wdata, 64'hABAB_ABAB_ABAB_ABAB);
            chk("t2_we", 64'(dmem_we), 64'd1);
            @(posedge clk); #1;
        end
        grant_and_respond(1'b0, 64'd0);
        @(negedge clk);
        chk("t2_store_done", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // 3: LB and LBU at offset 1
        sb.push_back('{wd: 5'd7, wreg: 1'b1, wdata: 64'hFFFF_FFFF_FFFF_FF80, exc: 1'b0});
        send(5'd7, 1'b1, 64'h1001, 1'b1, 1'b0, 3'b000, 64'd0);
        chk("t3_lb_wmask", 64'(dmem_wmask), 64'h02);
        chk("t3_lb_we", 64'(dmem_we), 64'd0);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        chk("t3_wait_req_low", 64'(dmem_req), 64'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 64'h0000_0000_0000_80FF;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        sb.push_back('{wd: 5'd8, wreg: 1'b1, wdata: 64'h80, exc: 1'b0});
        send(5'd8, 1'b1, 64'h1001, 1'b1, 1'b0, 3'b100, 64'd0);
        grant_and_respond(1'b1, 64'h0000_0000_0000_80FF);

        // 4: misaligned LW raises an exception without touching memory
        sb.push_back('{wd: 5'd9, wreg: 1'b0, wdata: 64'h1002, exc: 1'b1});
        send(5'd9, 1'b1, 64'h1002, 1'b1, 1'b0, 3'b010, 64'd0);
        @(negedge clk);
        chk("t4_no_req", 64'(dmem_req), 64'd0);
        chk("t4_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // 5: LD result held under backpressure, following ALU op waits then flows
        out_ready = 1'b0;
        sb.push_back('{wd: 5'd10, wreg: 1'b1, wdata: 64'h1122_3344_5566_7788, exc: 1'b0});
        send(5'd10, 1'b1, 64'h2000, 1'b1, 1'b0, 3'b011, 64'd0);
        grant_and_respond(1'b1, 64'h1122_3344_5566_7788);
        in_valid = 1'b1; in_wd = 5'd3; in_wreg = 1'b1; in_wdata = 64'h55;
        in_mem_en = 1'b0; in_mem_we = 1'b0; in_funct3 = 3'b000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t5_hold_valid", 64'(out_valid), 64'd1);
            chk("t5_hold_data", out_wdata, 64'h1122_3344_5566_7788);
            chk("t5_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        sb.push_back('{wd: 5'd3, wreg: 1'b1, wdata: 64'h55, exc: 1'b0});
        @(negedge clk);
        chk("t5_accept_on_consume", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_alu_no_bubble", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // 6: reset while waiting for load data
        send(5'd11, 1'b1, 64'h3000, 1'b1, 1'b0, 3'b010, 64'd0);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 64'(dmem_req), 64'd0);
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 64'hDEAD_BEEF;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_late_rvalid_ignored", 64'(out_valid), 64'd0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
